// File: rtl/wb_merge_queue_if.sv
// Bus bundle for wb_merge_queue: producer request lanes, register-file write port
// and the decode hazard lookup. The slave modport is the queue itself.
interface wb_merge_queue_if #(
    parameter int CHANNELS = 3,
    parameter int ARCH     = 64,
    parameter int TAGW     = 3
);
    logic [CHANNELS-1:0]      i_req_valid;
    logic [CHANNELS*6-1:0]    i_req_waddr;
    logic [CHANNELS*ARCH-1:0] i_req_wdata;
    logic [CHANNELS*TAGW-1:0] i_req_wtag;
    logic [CHANNELS-1:0]      o_req_ready;
    logic                     i_wb_ready;
    logic                     o_wena;
    logic [5:0]               o_waddr;
    logic [ARCH-1:0]          o_wdata;
    logic [TAGW-1:0]          o_wtag;
    logic [5:0]               i_chk_addr;
    logic                     o_chk_hit;
    logic                     o_idle;

    modport slave (
        input  i_req_valid, i_req_waddr, i_req_wdata, i_req_wtag, i_wb_ready, i_chk_addr,
        output o_req_ready, o_wena, o_waddr, o_wdata, o_wtag, o_chk_hit, o_idle
    );

    modport master (
        output i_req_valid, i_req_waddr, i_req_wdata, i_req_wtag, i_wb_ready, i_chk_addr,
        input  o_req_ready, o_wena, o_waddr, o_wdata, o_wtag, o_chk_hit, o_idle
    );
endinterface

// File: rtl/wb_merge_queue.sv
// Write-back merge queue: per-producer FIFOs drained round-robin into one RF write port.
// Optional same-cycle bypass when all FIFOs are empty: define WB_MERGE_BYPASS_EN.
module wb_merge_fifo #(
    parameter int DEPTH = 4,
    parameter int EW    = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [EW-1:0]                wentry,
    output logic [EW-1:0]                head,
    output logic [$clog2(DEPTH+1)-1:0]   cnt,
    input  logic [5:0]                   chk_addr,
    output logic                         hit
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, off;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides which slots are live.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= wentry;
    end

    assign head = mem[rd_ptr];

    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ((CW'(off) < cnt) && (mem[i][EW-1 -: 6] == chk_addr)) hit = 1'b1;
        end
    end
endmodule

module wb_merge_queue #(
    parameter int CHANNELS = 3,
    parameter int DEPTH    = 4,
    parameter int ARCH     = 64,
    parameter int TAGW     = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    wb_merge_queue_if.slave bus
);
    localparam int RW = $clog2(CHANNELS);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [5:0]      addr;
        logic [TAGW-1:0] tag;
        logic [ARCH-1:0] data;
    } wb_entry_t;
    localparam int EW = $bits(wb_entry_t);

    wb_entry_t [CHANNELS-1:0]         req, head;
    logic [CHANNELS-1:0][CW-1:0]      cnt;
    logic [CHANNELS-1:0]              nonempty, ready, push, pop, hit, byp_hot;
    logic [RW-1:0]                    rr, grant, byp_ch;
    logic                             grant_vld, byp_act, xfer, wena;
    wb_entry_t                        out_e;

    function automatic logic [RW-1:0] rr_next(input logic [RW-1:0] g);
        return (int'(g) == CHANNELS-1) ? '0 : g + RW'(1);
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign req[c].addr  = bus.i_req_waddr[6*c +: 6];
        assign req[c].tag   = bus.i_req_wtag[TAGW*c +: TAGW];
        assign req[c].data  = bus.i_req_wdata[ARCH*c +: ARCH];
        assign ready[c]     = cnt[c] != CW'(DEPTH);
        assign nonempty[c]  = cnt[c] != '0;
        // x0 writes are accepted but never stored
        assign push[c] = bus.i_req_valid[c] & ready[c] & (req[c].addr != 6'd0) & ~byp_hot[c];
        assign pop[c]  = xfer & (grant == RW'(c));

        wb_merge_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .push     (push[c]),
            .pop      (pop[c]),
            .wentry   (req[c]),
            .head     (head[c]),
            .cnt      (cnt[c]),
            .chk_addr (bus.i_chk_addr),
            .hit      (hit[c])
        );
    end

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!grant_vld && nonempty[(int'(rr) + k) % CHANNELS]) begin
                grant_vld = 1'b1;
                grant     = RW'((int'(rr) + k) % CHANNELS);
            end
        end
    end

`ifdef WB_MERGE_BYPASS_EN
    // Only when nothing is queued, so bypassing can never reorder a channel.
    always_comb begin
        byp_act = 1'b0;
        byp_ch  = '0;
        byp_hot = '0;
        if (!grant_vld && bus.i_wb_ready && !i_rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (!byp_act && bus.i_req_valid[(int'(rr) + k) % CHANNELS] &&
                    req[(int'(rr) + k) % CHANNELS].addr != 6'd0) begin
                    byp_act = 1'b1;
                    byp_ch  = RW'((int'(rr) + k) % CHANNELS);
                end
            end
            if (byp_act) byp_hot[byp_ch] = 1'b1;
        end
    end
`else
    assign byp_act = 1'b0;
    assign byp_ch  = '0;
    assign byp_hot = '0;
`endif

    assign xfer  = grant_vld & bus.i_wb_ready;
    assign wena  = grant_vld | byp_act;
    assign out_e = byp_act ? req[byp_ch] : head[grant];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        rr <= '0;
        else if (xfer)    rr <= rr_next(grant);
        else if (byp_act) rr <= rr_next(byp_ch);
    end

    assign bus.o_req_ready = ready;
    assign bus.o_wena      = wena;
    assign bus.o_waddr     = wena ? out_e.addr : '0;
    assign bus.o_wdata     = wena ? out_e.data : '0;
    assign bus.o_wtag      = wena ? out_e.tag  : '0;
    assign bus.o_idle      = ~|nonempty;
    assign bus.o_chk_hit   = (bus.i_chk_addr != 6'd0) &
                             ((|hit) | (byp_act & (req[byp_ch].addr == bus.i_chk_addr)));
endmodule

// File: tb/tb_wb_merge_queue.sv
// Directed + random bench for wb_merge_queue (default build, no bypass), checked
// against a queue-based reference model of the round-robin drain.
module tb_wb_merge_queue;
    localparam int CH = 3, DEPTH = 4, ARCH = 64, TAGW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_merge_queue_if #(.CHANNELS(CH), .ARCH(ARCH), .TAGW(TAGW)) bus ();

    wb_merge_queue #(.CHANNELS(CH), .DEPTH(DEPTH), .ARCH(ARCH), .TAGW(TAGW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]      addr;
        logic [ARCH-1:0] data;
        logic [TAGW-1:0] tag;
    } ent_t;

    ent_t q[CH][$];
    int   rr;
    int   gseq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic [5:0] a, input logic [63:0] d, input logic [2:0] t);
        bus.i_req_valid[c]              = 1'b1;
        bus.i_req_waddr[6*c +: 6]       = a;
        bus.i_req_wdata[ARCH*c +: ARCH] = d;
        bus.i_req_wtag[TAGW*c +: TAGW]  = t;
    endtask

    // Called at a falling edge with inputs applied; checks, advances the model, clocks once.
    task automatic step();
        bit              any;
        int              g;
        logic [CH-1:0]   rdy;
        bit              idle, hit;
        ent_t            e;
        #1;
        any = 0; g = 0; idle = 1; hit = 0;
        for (int k = 0; k < CH; k++)
            if (!any && q[(rr + k) % CH].size() != 0) begin any = 1; g = (rr + k) % CH; end
        for (int c = 0; c < CH; c++) begin
            rdy[c] = q[c].size() != DEPTH;
            if (q[c].size() != 0) idle = 0;
            foreach (q[c][i]) if (bus.i_chk_addr != 0 && q[c][i].addr == bus.i_chk_addr) hit = 1;
        end
        chk("wena", 64'(bus.o_wena), 64'(any));
        if (any) begin
            chk("waddr", 64'(bus.o_waddr), 64'(q[g][0].addr));
            chk("wdata", 64'(bus.o_wdata), 64'(q[g][0].data));
            chk("wtag",  64'(bus.o_wtag),  64'(q[g][0].tag));
        end
        chk("req_ready", 64'(bus.o_req_ready), 64'(rdy));
        chk("idle",      64'(bus.o_idle),      64'(idle));
        chk("chk_hit",   64'(bus.o_chk_hit),   64'(hit));
        if (any && bus.i_wb_ready) begin
            void'(q[g].pop_front());
            rr = (g + 1) % CH;
            gseq.push_back(g);
        end
        for (int c = 0; c < CH; c++) begin
            if (bus.i_req_valid[c] && rdy[c] && bus.i_req_waddr[6*c +: 6] != 0) begin
                e.addr = bus.i_req_waddr[6*c +: 6];
                e.data = bus.i_req_wdata[ARCH*c +: ARCH];
                e.tag  = bus.i_req_wtag[TAGW*c +: TAGW];
                q[c].push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.i_req_valid = '0;
    endtask

    task automatic reset_checks(input string tag);
        #1;
        chk({tag, "_wena"},  64'(bus.o_wena), 64'(0));
        chk({tag, "_idle"},  64'(bus.o_idle), 64'(1));
        chk({tag, "_ready"}, 64'(bus.o_req_ready), 64'(3'b111));
        chk({tag, "_waddr"}, 64'(bus.o_waddr), 64'(0));
        chk({tag, "_wdata"}, 64'(bus.o_wdata), 64'(0));
        chk({tag, "_hit"},   64'(bus.o_chk_hit), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reset_checks("rst_async");
        for (int c = 0; c < CH; c++) q[c].delete();
        rr = 0;
        @(negedge clk);
        reset_checks("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_req_valid = '0; bus.i_req_waddr = '0; bus.i_req_wdata = '0; bus.i_req_wtag = '0;
        bus.i_wb_ready = 1'b0; bus.i_chk_addr = '0;
        rr = 0;
        @(negedge clk);
        reset_checks("por");
        rst = 1'b0;

        // single write on ch1: visible one cycle after acceptance, then idle again
        bus.i_wb_ready = 1'b1;
        drive(1, 6'd5, 64'h1234, 3'd2);
        step(); step(); step();

        // round robin: 4 entries per channel, then 12 writes back-to-back
        do_reset();
        bus.i_wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int c = 0; c < CH; c++) drive(c, 6'(8 * c + i + 1), {$urandom(), $urandom()}, 3'(i));
            step();
        end
        bus.i_wb_ready = 1'b1;
        gseq.delete();
        repeat (12) step();
        chk("rr_count", 64'(gseq.size()), 64'(12));
        for (int i = 0; i < gseq.size(); i++) chk("rr_seq", 64'(gseq[i]), 64'(i % CH));

        // full ch0 under backpressure; 5th held; push while full+pop is refused
        do_reset();
        bus.i_wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'(10 + i), 64'(100 + i), 3'(i));
            step();
        end
        #1 chk("full_ready0", 64'(bus.o_req_ready[0]), 64'(0));
        drive(0, 6'd14, 64'd104, 3'd4); step();
        drive(0, 6'd14, 64'd104, 3'd4); step();
        bus.i_wb_ready = 1'b1;
        drive(0, 6'd14, 64'd104, 3'd4); step();
        #1 chk("pushpop_ready0", 64'(bus.o_req_ready[0]), 64'(1));
        drive(0, 6'd14, 64'd104, 3'd4); step();
        repeat (5) step();

        // x0 discard plus hazard lookup
        do_reset();
        bus.i_wb_ready = 1'b0;
        drive(2, 6'd0, 64'hdead, 3'd1); step();
        #1 chk("x0_idle", 64'(bus.o_idle), 64'(1));
        drive(2, 6'd7, 64'hbeef, 3'd3); step();
        bus.i_chk_addr = 6'd7; step();
        #1 chk("hit_x7", 64'(bus.o_chk_hit), 64'(1));
        bus.i_chk_addr = 6'd0; step();
        bus.i_chk_addr = 6'd3; step();

        // reset mid-stream with 3 entries queued: nothing may come out afterwards
        drive(0, 6'd1, 64'h11, 3'd1); drive(1, 6'd2, 64'h22, 3'd2); step();
        do_reset();
        bus.i_wb_ready = 1'b1;
        repeat (3) step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 1) == 1)
                    drive(c, 6'($urandom_range(0, 15)), {$urandom(), $urandom()}, 3'($urandom_range(0, 7)));
            bus.i_chk_addr = 6'($urandom_range(0, 15));
            bus.i_wb_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.i_wb_ready = 1'b1;
        repeat (3 * DEPTH) step();
        #1 chk("final_idle", 64'(bus.o_idle), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
